// File: rtl/alu_pipe_acc.sv
// alu_pipe_acc: WIDTH-bit 8-op ALU with a two-stage valid/ready pipeline.
// S1 holds the operand beat. S2 holds the result and its flags.
// An internal accumulator can stand in for operand B, and the result of such an op
// is written back to the accumulator.
module alu_pipe_acc #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [2:0]       ALU_Sel,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             Cout,
  output logic             Zero,
  output logic             Neg,
  output logic             Ovf
);

  // Stage S1: operand register
  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_x_reg;
  logic [WIDTH-1:0] s1_y_reg;
  logic [2:0]       s1_sel_reg;
  logic             s1_acc_reg;

  // Stage S2: result register
  logic             out_valid_reg;
  logic [WIDTH-1:0] result_reg;
  logic             cout_reg;
  logic             zero_reg;
  logic             neg_reg;
  logic             ovf_reg;

  logic [WIDTH-1:0] acc_reg;

  // Datapath computed from S1 contents and the current accumulator
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] and_bits;
  logic [WIDTH-1:0] or_bits;
  logic [WIDTH-1:0] xor_bits;
  logic [WIDTH-1:0] result_next;
  logic             cout_next;
  logic             ovf_next;

  logic s1_adv;
  logic in_fire;

  // S1 may move into S2 when S2 is empty or is being drained on this edge.
  assign s1_adv   = s1_valid_reg && (!out_valid_reg || out_ready);
  assign in_ready = !s1_valid_reg || s1_adv;
  assign in_fire  = in_valid && in_ready;

  // When the accumulator is selected, it replaces Y as operand B.
  assign operand_b = s1_acc_reg ? acc_reg : s1_y_reg;

  // The extra MSB is the carry for ADD and the borrow for SUB.
  assign sum_ext  = {1'b0, s1_x_reg} + {1'b0, operand_b};
  assign diff_ext = {1'b0, s1_x_reg} - {1'b0, operand_b};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
      assign and_bits[gi] = s1_x_reg[gi] & operand_b[gi];
      assign or_bits[gi]  = s1_x_reg[gi] | operand_b[gi];
      assign xor_bits[gi] = s1_x_reg[gi] ^ operand_b[gi];
    end
  endgenerate

  // Opcode decode: result, carry/borrow and signed overflow
  always_comb begin
    result_next = '0;
    cout_next   = 1'b0;
    ovf_next    = 1'b0;
    case (s1_sel_reg)
      3'b000: begin
        result_next = sum_ext[WIDTH-1:0];
        cout_next   = sum_ext[WIDTH];
        ovf_next    = (s1_x_reg[WIDTH-1] == operand_b[WIDTH-1]) &&
                      (sum_ext[WIDTH-1] != s1_x_reg[WIDTH-1]);
      end
      3'b001: begin
        result_next = diff_ext[WIDTH-1:0];
        cout_next   = diff_ext[WIDTH];
        ovf_next    = (s1_x_reg[WIDTH-1] != operand_b[WIDTH-1]) &&
                      (diff_ext[WIDTH-1] != s1_x_reg[WIDTH-1]);
      end
      3'b010:  result_next = and_bits;
      3'b011:  result_next = or_bits;
      3'b100:  result_next = ~and_bits;
      3'b101:  result_next = xor_bits;
      3'b110:  result_next = ~xor_bits;
      default: result_next = ~or_bits;
    endcase
  end

  // S1: capture an accepted beat, or empty the stage once it has advanced
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_x_reg     <= '0;
      s1_y_reg     <= '0;
      s1_sel_reg   <= 3'b000;
      s1_acc_reg   <= 1'b0;
    end else if (in_fire) begin
      s1_valid_reg <= 1'b1;
      s1_x_reg     <= X;
      s1_y_reg     <= Y;
      s1_sel_reg   <= ALU_Sel;
      s1_acc_reg   <= in_acc;
    end else if (s1_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // S2: load a new result on advance; otherwise hold it until the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      cout_reg      <= 1'b0;
      zero_reg      <= 1'b1;
      neg_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
    end else if (s1_adv) begin
      out_valid_reg <= 1'b1;
      result_reg    <= result_next;
      cout_reg      <= cout_next;
      zero_reg      <= (result_next == '0);
      neg_reg       <= result_next[WIDTH-1];
      ovf_reg       <= ovf_next;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Accumulator write-back on the same edge the accumulating op computes.
  // This lets back-to-back accumulating ops chain without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= ACC_INIT;
    end else if (s1_adv && s1_acc_reg) begin
      acc_reg <= result_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign ALU_Out   = result_reg;
  assign Cout      = cout_reg;
  assign Zero      = zero_reg;
  assign Neg       = neg_reg;
  assign Ovf       = ovf_reg;

endmodule
